dcache_writeback: RTL and testbench

Write-back engine on the memory side of the data cache. It accepts one evicted dirty line from the cache controller: 512-bit data, 20-bit tag and 6-bit index. It writes the line to memory as one AXI4 INCR write burst of 16 × 32-bit beats, then reports completion so the controller can clear the line's dirty bit or refill it. This block is the reader/drain side of the cache line storage, which the refill path fills.

---
 rtl/dcache_writeback.sv | 130 +++++++++++++
 tb/tb_dcache_writeback.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_writeback.sv
// Data-cache write-back engine: drains one evicted dirty line to memory
// as a single AXI4 INCR write burst and reports the write response.
module dcache_writeback #(
    parameter int         INDEX_SIZE    = 6,
    parameter int         WORD_OFF_SIZE = 4,
    parameter int         TAG_SIZE      = 20,
    parameter logic [3:0] AXI_ID        = 4'd1
) (
    input  logic                              clk,
    input  logic                              resetn,

    input  logic                              wb_req,
    output logic                              wb_ready,
    input  logic [TAG_SIZE-1:0]               wb_tag,
    input  logic [INDEX_SIZE-1:0]             wb_index,
    input  logic [(32<<WORD_OFF_SIZE)-1:0]    wb_line,
    output logic                              wb_done,
    output logic                              wb_err,

    output logic [3:0]                        awid,
    output logic [31:0]                       awaddr,
    output logic [7:0]                        awlen,
    output logic [2:0]                        awsize,
    output logic [1:0]                        awburst,
    output logic                              awvalid,
    input  logic                              awready,

    output logic [31:0]                       wdata,
    output logic [3:0]                        wstrb,
    output logic                              wlast,
    output logic                              wvalid,
    input  logic                              wready,

    input  logic [3:0]                        bid,
    input  logic [1:0]                        bresp,
    input  logic                              bvalid,
    output logic                              bready
);

    localparam int BEATS     = 1 << WORD_OFF_SIZE;
    localparam int LINE_BITS = 32 * BEATS;
    localparam int OFF_BITS  = WORD_OFF_SIZE + 2;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] AW   = 3'd1;
    localparam logic [2:0] W    = 3'd2;
    localparam logic [2:0] B    = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]               state;
    logic [2:0]               state_next;
    logic [WORD_OFF_SIZE-1:0] cnt;
    logic [LINE_BITS-1:0]     line;
    logic [31:0]              addr;
    logic                     err;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic last_hs;
    logic b_hs;

    assign accept  = (state == IDLE) && wb_req;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign last_hs = w_hs && (cnt == '1);
    assign b_hs    = bready && bvalid;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept)  state_next = AW;
            AW:   if (aw_hs)   state_next = W;
            W:    if (last_hs) state_next = B;
            B:    if (b_hs)    state_next = DONE;
            DONE:              state_next = IDLE;
            default:           state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            if (aw_hs) begin
                cnt <= '0;
            end else if (w_hs) begin
                cnt <= cnt + 1'b1;
            end
            if (b_hs) begin
                err <= bresp[1];
            end
        end
    end

    // Line and address are snapshots; the controller may reuse its
    // victim buffer as soon as the request is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            line <= wb_line;
            addr <= {wb_tag, wb_index, {OFF_BITS{1'b0}}};
        end
    end

    assign wb_ready = (state == IDLE);
    assign wb_done  = (state == DONE);
    assign wb_err   = err;

    assign awid    = AXI_ID;
    assign awaddr  = addr;
    assign awlen   = 8'(BEATS - 1);
    assign awsize  = 3'b010;
    assign awburst = 2'b01;
    assign awvalid = (state == AW);

    assign wdata  = line[{cnt, 5'b0} +: 32];
    assign wstrb  = 4'hF;
    assign wlast  = (state == W) && (cnt == '1);
    assign wvalid = (state == W);

    assign bready = (state == B);

    // Response id and the OKAY/EXOKAY distinction carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{bid, bresp[0]};

endmodule

// File: tb/tb_dcache_writeback.sv
// Bench for dcache_writeback: vector table of write-back transactions,
// AXI slave model with configurable stalls, beat/address scoreboard.
module tb_dcache_writeback;

    logic         clk = 1'b0;
    logic         resetn;
    logic         wb_req;
    logic         wb_ready;
    logic [19:0]  wb_tag;
    logic [5:0]   wb_index;
    logic [511:0] wb_line;
    logic         wb_done;
    logic         wb_err;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready = 1'b0;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready = 1'b0;
    logic [3:0]   bid = 4'd0;
    logic [1:0]   bresp = 2'b00;
    logic         bvalid = 1'b0;
    logic         bready;

    dcache_writeback dut (
        .clk      (clk),
        .resetn   (resetn),
        .wb_req   (wb_req),
        .wb_ready (wb_ready),
        .wb_tag   (wb_tag),
        .wb_index (wb_index),
        .wb_line  (wb_line),
        .wb_done  (wb_done),
        .wb_err   (wb_err),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .awsize   (awsize),
        .awburst  (awburst),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .wvalid   (wvalid),
        .wready   (wready),
        .bid      (bid),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] tag;
        logic [5:0]  idx;
        logic [31:0] base;
        int          awd;
        bit          tog;
        logic [1:0]  resp;
        logic [31:0] addr;
        bit          err;
        bit          modify;
        bit          busy;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        bit          last;
    } beat_t;

    vec_t        vecs[8];
    beat_t       exp_q[$];
    logic [31:0] addr_q[$];

    int tests = 0;
    int fails = 0;
    int beats = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    int         aw_delay = 0;
    bit         w_tog = 1'b0;
    logic [1:0] cur_resp = 2'b00;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // AXI slave: awready after aw_delay stall cycles, wready optionally
    // toggling, bvalid answered in the first cycle bready is seen.
    int aw_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!awvalid) begin
            awready = 1'b0;
            aw_cnt  = 0;
        end else if (aw_cnt >= aw_delay) begin
            awready = 1'b1;
        end else begin
            awready = 1'b0;
            aw_cnt++;
        end
        wready = w_tog ? ~wready : 1'b1;
        bvalid = bready;
        bresp  = cur_resp;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("aw_w_overlap", 64'(awvalid & wvalid), 64'd0);
            if (awvalid) begin
                if (addr_q.size() == 0) begin
                    check("aw_unexpected", 64'(awvalid), 64'd0);
                end else begin
                    check(awready ? "awaddr" : "awaddr_stall",
                          64'(awaddr), 64'(addr_q[0]));
                    if (awready) begin
                        check("aw_fields",
                              64'({awid, awlen, awsize, awburst}),
                              64'({4'd1, 8'd15, 3'b010, 2'b01}));
                        void'(addr_q.pop_front());
                    end
                end
            end
            if (wvalid) begin
                if (exp_q.size() == 0) begin
                    check("w_unexpected", 64'(wvalid), 64'd0);
                end else begin
                    check(wready ? "wdata" : "wdata_stall",
                          64'(wdata), 64'(exp_q[0].data));
                    check(wready ? "wlast" : "wlast_stall",
                          64'(wlast), 64'(exp_q[0].last));
                    if (wready) begin
                        check("wstrb", 64'(wstrb), 64'hF);
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
        end
    end

    task automatic load(input vec_t v, output logic [511:0] line);
        for (int k = 0; k < 16; k++) begin
            line[32*k +: 32] = v.base + 32'(k);
            exp_q.push_back('{v.base + 32'(k), k == 15});
        end
        addr_q.push_back(v.addr);
        aw_delay = v.awd;
        w_tog    = v.tog;
        cur_resp = v.resp;
    endtask

    task automatic issue(input vec_t v, input logic [511:0] line,
                         output int b0, output int t0);
        int n = 0;
        while (!wb_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", 64'(wb_ready), 64'd1);
        b0       = beats;
        wb_tag   = v.tag;
        wb_index = v.idx;
        wb_line  = line;
        wb_req   = 1'b1;
        @(posedge clk); #1;
        t0     = cyc;
        wb_req = 1'b0;
        check("accept_busy", 64'(wb_ready), 64'd0);
        check("aw_latency", 64'(awvalid), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [511:0] line;
        int b0;
        int t0;
        int n = 0;
        load(v, line);
        issue(v, line, b0, t0);
        if (v.modify) wb_line = ~line;
        if (v.busy) begin
            while (!wvalid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            wb_req   = 1'b1;
            wb_tag   = 20'h22222;
            wb_index = 6'h22;
            wb_line  = {16{32'hDEAD_BEEF}};
            repeat (4) begin
                @(posedge clk); #1;
                check("busy_ready", 64'(wb_ready), 64'd0);
            end
            wb_req = 1'b0;
        end
        n = 0;
        while (!wb_done && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 64'(wb_done), 64'd1);
        check("wb_err", 64'(wb_err), 64'(v.err));
        check("beat_count", 64'(beats - b0), 64'd16);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        if (!v.tog) check("latency", 64'(cyc - t0), 64'(18 + v.awd));
        @(posedge clk); #1;
        check("done_pulse", 64'(wb_done), 64'd0);
        check("ready_back", 64'(wb_ready), 64'd1);
        check("err_hold", 64'(wb_err), 64'(v.err));
    endtask

    initial begin
        vec_t         rv;
        logic [511:0] rline;
        int           b0;
        int           t0;
        int           n;

        vecs[0] = '{20'hABCDE, 6'h2A, 32'h1000_0000, 0, 1'b0, 2'b00,
                    32'hABCD_EA80, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{20'h12345, 6'h3F, 32'h2000_0000, 3, 1'b1, 2'b00,
                    32'h1234_5FC0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{20'hFFFFF, 6'h00, 32'hA5A5_0000, 0, 1'b0, 2'b10,
                    32'hFFFF_F000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{20'h00001, 6'h01, 32'h4000_0000, 2, 1'b0, 2'b00,
                    32'h0000_1040, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{20'h0F0F0, 6'h15, 32'h5000_0000, 0, 1'b1, 2'b11,
                    32'h0F0F_0540, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{20'h5A5A5, 6'h2B, 32'h6000_0000, 1, 1'b0, 2'b01,
                    32'h5A5A_5AC0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{20'h11111, 6'h11, 32'h8000_0000, 0, 1'b0, 2'b00,
                    32'h1111_1440, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{20'h22222, 6'h22, 32'h7000_0000, 0, 1'b0, 2'b00,
                    32'h2222_2880, 1'b0, 1'b0, 1'b0};

        resetn   = 1'b0;
        wb_req   = 1'b0;
        wb_tag   = '0;
        wb_index = '0;
        wb_line  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_awvalid", 64'(awvalid), 64'd0);
        check("rst_wvalid", 64'(wvalid), 64'd0);
        check("rst_bready", 64'(bready), 64'd0);
        check("rst_done", 64'(wb_done), 64'd0);
        check("rst_err", 64'(wb_err), 64'd0);
        check("rst_ready", 64'(wb_ready), 64'd1);
        resetn = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset while beat 7 is on the bus, then a clean burst.
        rv = '{20'h33333, 6'h07, 32'h3000_0000, 0, 1'b0, 2'b00,
               32'h3333_31C0, 1'b0, 1'b0, 1'b0};
        load(rv, rline);
        issue(rv, rline, b0, t0);
        n = 0;
        while ((beats - b0) < 7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_beats", 64'(beats - b0), 64'd7);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("mid_awvalid", 64'(awvalid), 64'd0);
        check("mid_wvalid", 64'(wvalid), 64'd0);
        check("mid_bready", 64'(bready), 64'd0);
        check("mid_ready", 64'(wb_ready), 64'd1);
        resetn = 1'b1;
        exp_q.delete();
        addr_q.delete();
        run_vec(vecs[0]);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no summary expected finish");
        $fatal(1);
    end

endmodule
